// File: rtl/spi_cmd_ram.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_ram
// Desc     : Opcode-decoded RAM slave behind the SPI shifter. It has separate
//            read/write pointers, optional auto-increment and a held
//            tx_valid/tx_ready read-data port.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_ram #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              addr_err
);

  localparam logic [1:0]           c_OP_WADDR = 2'b00;
  localparam logic [1:0]           c_OP_WDATA = 2'b01;
  localparam logic [1:0]           c_OP_RADDR = 2'b10;
  localparam logic [1:0]           c_OP_RDATA = 2'b11;
  // One bit wider than a pointer so that a full 2^ADDR_SIZE depth is representable
  localparam logic [ADDR_SIZE:0]   c_DEPTH    = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] c_LAST     = ADDR_SIZE'(MEM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [DATA_W-1:0]   r_dout;
  logic                r_addr_err;

  logic                w_accept;
  logic [1:0]          w_op;
  logic [ADDR_SIZE-1:0] w_addr;
  logic                w_addr_ok;
  logic                w_wr_acc;
  logic                w_rd_acc;

  function automatic logic [ADDR_SIZE-1:0] f_next(input logic [ADDR_SIZE-1:0] p);
    return (p == c_LAST) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  assign rx_ready  = ~((r_state == ST_HOLD) & ~tx_ready);
  assign w_accept  = rx_valid & rx_ready;
  assign w_op      = din[DATA_W+1:DATA_W];
  assign w_addr    = din[ADDR_SIZE-1:0];
  assign w_addr_ok = ({1'b0, w_addr} < c_DEPTH);
  assign w_wr_acc  = w_accept & (w_op == c_OP_WDATA);
  assign w_rd_acc  = w_accept & (w_op == c_OP_RDATA);

  assign tx_valid  = (r_state == ST_HOLD);
  assign dout      = r_dout;
  assign addr_err  = r_addr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_addr_err <= 1'b0;
    end else if (w_accept) begin
      case (w_op)
        c_OP_WADDR: begin
          if (w_addr_ok) r_wr_ptr <= w_addr;
          else           r_addr_err <= 1'b1;
        end
        c_OP_WDATA: begin
          if (AUTO_INC) r_wr_ptr <= f_next(r_wr_ptr);
        end
        c_OP_RADDR: begin
          if (w_addr_ok) r_rd_ptr <= w_addr;
          else           r_addr_err <= 1'b1;
        end
        default: begin
          if (AUTO_INC) r_rd_ptr <= f_next(r_rd_ptr);
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dout  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_acc) begin
            r_state <= ST_HOLD;
            r_dout  <= r_mem[r_rd_ptr];
          end
        end
        default: begin
          if (tx_ready) begin
            if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
            else          r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_ram
// Desc     : Directed vector bench for spi_cmd_ram across three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din      [3];
  logic       rx_valid [3];
  logic       rx_ready [3];
  logic       tx_ready [3];
  logic       tx_valid [3];
  logic [7:0] dout     [3];
  logic       addr_err [3];

  int n_checks;
  int n_fails;

  typedef struct {
    int         u;
    logic       rv;
    logic [1:0] op;
    logic [7:0] pl;
    logic       tr;
    logic       e_rr;
    logic       e_tv;
    logic       chk;
    logic [7:0] e_dout;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  // u0: plain, u1: burst at full depth, u2: burst at non-power-of-2 depth
  spi_cmd_ram #(.DATA_W(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_ready(tx_ready[0]), .tx_valid(tx_valid[0]), .dout(dout[0]), .addr_err(addr_err[0]));
  spi_cmd_ram #(.DATA_W(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .tx_ready(tx_ready[1]), .tx_valid(tx_valid[1]), .dout(dout[1]), .addr_err(addr_err[1]));
  spi_cmd_ram #(.DATA_W(8), .MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
    .tx_ready(tx_ready[2]), .tx_valid(tx_valid[2]), .dout(dout[2]), .addr_err(addr_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic v(input int u, input logic rv, input logic [1:0] op, input logic [7:0] pl,
                   input logic tr, input logic e_rr, input logic e_tv, input logic chk,
                   input logic [7:0] e_dout, input logic e_err);
    vec_t t;
    t.u = u; t.rv = rv; t.op = op; t.pl = pl; t.tr = tr;
    t.e_rr = e_rr; t.e_tv = e_tv; t.chk = chk; t.e_dout = e_dout; t.e_err = e_err;
    tbl.push_back(t);
  endtask

  task automatic check1(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  // Each vector is one clock: rx_ready sampled before the edge, state after it
  task automatic run_table();
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) rx_valid[j] = 1'b0;
      din[tbl[k].u]      = {tbl[k].op, tbl[k].pl};
      rx_valid[tbl[k].u] = tbl[k].rv;
      tx_ready[tbl[k].u] = tbl[k].tr;
      #1;
      check1("rx_ready", k, {7'd0, rx_ready[tbl[k].u]}, {7'd0, tbl[k].e_rr});
      @(posedge clk);
      #1;
      check1("tx_valid", k, {7'd0, tx_valid[tbl[k].u]}, {7'd0, tbl[k].e_tv});
      check1("addr_err", k, {7'd0, addr_err[tbl[k].u]}, {7'd0, tbl[k].e_err});
      if (tbl[k].chk) check1("dout", k, dout[tbl[k].u], tbl[k].e_dout);
    end
    tbl.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    for (int j = 0; j < 3; j++) begin
      din[j] = '0; rx_valid[j] = 1'b0; tx_ready[j] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    v(0, 0, 2'd0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    v(1, 0, 2'd0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    v(2, 0, 2'd0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    // u0 basic write/read, no auto-increment
    v(0, 1, 2'd0, 8'h10, 0, 1, 0, 0, 8'h00, 0);
    v(0, 1, 2'd1, 8'hA5, 0, 1, 0, 0, 8'h00, 0);
    v(0, 1, 2'd2, 8'h10, 0, 1, 0, 0, 8'h00, 0);
    v(0, 1, 2'd3, 8'h00, 0, 1, 1, 1, 8'hA5, 0);
    v(0, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'hA5, 0);
    v(0, 0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    // u1 burst write across 0xFF->0x00, then burst read
    v(1, 1, 2'd0, 8'hFE, 0, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd1, 8'h11, 0, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd1, 8'h22, 0, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd1, 8'h33, 0, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd2, 8'hFE, 1, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'h11, 0);
    v(1, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'h22, 0);
    v(1, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'h33, 0);
    v(1, 0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd2, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'h33, 0);
    v(1, 0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    // u1 backpressure: five stalled writes must not touch memory or wr_ptr
    v(1, 1, 2'd0, 8'h40, 0, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd2, 8'h00, 0, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd3, 8'h00, 0, 1, 1, 1, 8'h33, 0);
    for (int s = 0; s < 5; s++) v(1, 1, 2'd1, 8'h77, 0, 0, 1, 1, 8'h33, 0);
    v(1, 1, 2'd1, 8'h77, 1, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd1, 8'h99, 1, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd2, 8'h41, 1, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'h99, 0);
    v(1, 1, 2'd2, 8'h40, 1, 1, 0, 0, 8'h00, 0);
    v(1, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'h77, 0);
    v(1, 0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    // u2 out-of-range and wrap at depth 200
    v(2, 1, 2'd0, 8'h05, 0, 1, 0, 0, 8'h00, 0);
    v(2, 1, 2'd0, 8'hC8, 0, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd1, 8'h5A, 0, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd0, 8'hC7, 0, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd1, 8'hE1, 0, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd1, 8'hB2, 0, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd2, 8'hC7, 1, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd2, 8'hC8, 1, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'hE1, 1);
    v(2, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'hB2, 1);
    v(2, 1, 2'd2, 8'h05, 1, 1, 0, 0, 8'h00, 1);
    v(2, 1, 2'd3, 8'h00, 1, 1, 1, 1, 8'h5A, 1);
    v(2, 0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h00, 1);
    // u0 left holding read data with nonzero pointers ahead of reset
    v(0, 1, 2'd0, 8'h33, 0, 1, 0, 0, 8'h00, 0);
    v(0, 1, 2'd3, 8'h00, 0, 1, 1, 1, 8'hA5, 0);
    v(0, 1, 2'd1, 8'h66, 0, 0, 1, 1, 8'hA5, 0);
    run_table();

    // asynchronous reset mid-HOLD, checked before any clock edge
    @(negedge clk);
    for (int j = 0; j < 3; j++) rx_valid[j] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check1("rst_tx_valid", 0, {7'd0, tx_valid[0]}, 8'h00);
    check1("rst_dout", 0, dout[0], 8'h00);
    check1("rst_addr_err", 2, {7'd0, addr_err[2]}, 8'h00);
    check1("rst_rx_ready", 0, {7'd0, rx_ready[0]}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;

    // pointers back at 0: write then read address 0
    v(0, 1, 2'd1, 8'h5A, 0, 1, 0, 1, 8'h00, 0);
    v(0, 1, 2'd3, 8'h00, 0, 1, 1, 1, 8'h5A, 0);
    v(0, 0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    v(2, 0, 2'd0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
